// File: rtl/mixer_sequencer.sv
// Per-sample scheduler for signal_mixer: snapshots active voices on each tick, fetches one
// sample per voice over req/ack, then commits all samples plus mask at once. Optional macro: MIXER_SEQ_TIMEOUT_EN.
module mixer_sequencer #(
   parameter int NUM_CH   = 12,
   parameter int TICK_DIV = 1000,
   parameter int TIMEOUT  = 15
) (
   input  logic                clk,
   input  logic                nrst,
   input  logic                en,
   input  logic [NUM_CH-1:0]   ch_active,
   output logic                fetch_req,
   output logic [3:0]          fetch_ch,
   input  logic                fetch_ack,
   input  logic [7:0]          fetch_data,
   output logic [8*NUM_CH-1:0] samples_flat,
   output logic [NUM_CH-1:0]   sample_enable,
   output logic                mix_valid,
   output logic                busy,
   output logic                overrun
);

   localparam int CW = $clog2(TICK_DIV);

   if (NUM_CH > 16 || TICK_DIV < 32 || TIMEOUT < 1) begin : g_param_check
      $error("mixer_sequencer: unsupported parameter set");
   end

   typedef enum logic [1:0] {IDLE, FETCH, WAIT, COMMIT} state_t;

   state_t                       state_q, state_d;
   logic [CW-1:0]                cnt_q, cnt_d;
   logic [NUM_CH-1:0]            pend_q, pend_d;
   logic [NUM_CH-1:0]            mask_q, mask_d;
   logic [NUM_CH-1:0][7:0]       shadow_q, shadow_d;
   logic [NUM_CH-1:0][7:0]       samples_q, samples_d;
   logic [NUM_CH-1:0]            enable_q, enable_d;
   logic                         req_q, req_d;
   logic [3:0]                   ch_q, ch_d;
   logic                         mix_valid_q, mix_valid_d;
   logic                         overrun_q, overrun_d;
   logic                         tick;
   logic [3:0]                   low_idx;
   logic [NUM_CH-1:0]            ch_bit;
   logic [NUM_CH-1:0]            pend_left;
`ifdef MIXER_SEQ_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0]                wcnt_q, wcnt_d;
`endif

   assign tick = en && (cnt_q == CW'(TICK_DIV - 1));

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pend_d      = pend_q;
      mask_d      = mask_q;
      shadow_d    = shadow_q;
      samples_d   = samples_q;
      enable_d    = enable_q;
      req_d       = req_q;
      ch_d        = ch_q;
      mix_valid_d = 1'b0;
      overrun_d   = overrun_q;
`ifdef MIXER_SEQ_TIMEOUT_EN
      wcnt_d      = '0;
`endif
      // descending scan leaves the lowest pending index
      low_idx = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (pend_q[i]) low_idx = 4'(i);
      end
      ch_bit    = NUM_CH'(1) << ch_q;
      pend_left = pend_q & ~ch_bit;

      if (!en || tick) cnt_d = '0;
      else             cnt_d = cnt_q + CW'(1);

      if (!en)                            overrun_d = 1'b0;
      else if (tick && state_q != IDLE)   overrun_d = 1'b1;

      case (state_q)
         IDLE: begin
            if (tick) begin
               pend_d  = ch_active;
               mask_d  = ch_active;
               state_d = (ch_active == '0) ? COMMIT : FETCH;
            end
         end
         FETCH: begin
            ch_d    = low_idx;
            req_d   = 1'b1;
            state_d = WAIT;
         end
         WAIT: begin
            if (fetch_ack && req_q) begin
               for (int i = 0; i < NUM_CH; i++) begin
                  if (ch_q == 4'(i)) shadow_d[i] = fetch_data;
               end
               pend_d  = pend_left;
               req_d   = 1'b0;
               state_d = (pend_left != '0) ? FETCH : COMMIT;
            end
`ifdef MIXER_SEQ_TIMEOUT_EN
            else if (wcnt_q == TW'(TIMEOUT - 1)) begin
               // silent voice: drop it from this sample entirely
               for (int i = 0; i < NUM_CH; i++) begin
                  if (ch_q == 4'(i)) shadow_d[i] = '0;
               end
               pend_d  = pend_left;
               mask_d  = mask_q & ~ch_bit;
               req_d   = 1'b0;
               state_d = (pend_left != '0) ? FETCH : COMMIT;
            end
            else begin
               wcnt_d = wcnt_q + TW'(1);
            end
`endif
         end
         COMMIT: begin
            for (int i = 0; i < NUM_CH; i++) begin
               samples_d[i] = mask_q[i] ? shadow_q[i] : 8'h00;
               shadow_d[i]  = mask_q[i] ? shadow_q[i] : 8'h00;
            end
            enable_d    = mask_q;
            mix_valid_d = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         pend_q      <= '0;
         mask_q      <= '0;
         shadow_q    <= '0;
         samples_q   <= '0;
         enable_q    <= '0;
         req_q       <= 1'b0;
         ch_q        <= '0;
         mix_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
`ifdef MIXER_SEQ_TIMEOUT_EN
         wcnt_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pend_q      <= pend_d;
         mask_q      <= mask_d;
         shadow_q    <= shadow_d;
         samples_q   <= samples_d;
         enable_q    <= enable_d;
         req_q       <= req_d;
         ch_q        <= ch_d;
         mix_valid_q <= mix_valid_d;
         overrun_q   <= overrun_d;
`ifdef MIXER_SEQ_TIMEOUT_EN
         wcnt_q      <= wcnt_d;
`endif
      end
   end

   assign fetch_req     = req_q;
   assign fetch_ch      = ch_q;
   assign samples_flat  = samples_q;
   assign sample_enable = enable_q;
   assign mix_valid     = mix_valid_q;
   assign busy          = (state_q != IDLE);
   assign overrun       = overrun_q;

endmodule

// File: tb/tb_mixer_sequencer.sv
// Directed bench for mixer_sequencer (TICK_DIV=32): vector table plus reset/overrun/timeout sequences.
module tb_mixer_sequencer;

   logic        clk = 1'b0;
   logic        nrst = 1'b1;
   logic        en = 1'b0;
   logic [11:0] ch_active = '0;
   logic        fetch_ack = 1'b0;
   logic [7:0]  fetch_data = '0;
   logic        fetch_req;
   logic [3:0]  fetch_ch;
   logic [95:0] samples_flat;
   logic [11:0] sample_enable;
   logic        mix_valid, busy, overrun;

   mixer_sequencer #(.NUM_CH(12), .TICK_DIV(32), .TIMEOUT(15)) dut (
      .clk(clk), .nrst(nrst), .en(en), .ch_active(ch_active),
      .fetch_req(fetch_req), .fetch_ch(fetch_ch), .fetch_ack(fetch_ack),
      .fetch_data(fetch_data), .samples_flat(samples_flat),
      .sample_enable(sample_enable), .mix_valid(mix_valid), .busy(busy),
      .overrun(overrun)
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0, cyc = 0;
   int ack_dly = 0, never_ch = -1, wait_cnt = 0;
   int got_ch[$];
   int stable_err = 0, run_len = 0, last_run = 0;
   logic prev_req = 1'b0;
   logic [3:0] prev_ch = '0;

   typedef struct {
      string       name;
      logic [11:0] act;
      int          dly;
      logic [11:0] exp_en;
      logic [95:0] exp_s;
      int          exp_lat;
   } vec_t;
   vec_t vecs[4];

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // voice model: acks after ack_dly waiting cycles with data 10+ch
   initial forever begin
      @(posedge clk); #2;
      if (fetch_req) begin
         if (wait_cnt >= ack_dly && int'(fetch_ch) != never_ch) begin
            fetch_ack  = 1'b1;
            fetch_data = 8'(10 + int'(fetch_ch));
            wait_cnt   = 0;
         end else begin
            fetch_ack = 1'b0;
            wait_cnt++;
         end
      end else begin
         fetch_ack = 1'b0;
         wait_cnt  = 0;
      end
   end

   initial forever begin
      @(posedge clk); #3;
      if (fetch_req) begin
         if (!prev_req) got_ch.push_back(int'(fetch_ch));
         else if (fetch_ch != prev_ch) stable_err++;
         run_len++;
      end else begin
         if (prev_req) last_run = run_len;
         run_len = 0;
      end
      prev_req = fetch_req;
      prev_ch  = fetch_ch;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic run_seq(input string name, input logic [11:0] act, input int dly,
                          input logic [11:0] exp_en, input logic [95:0] exp_s,
                          input int exp_lat, input bit drop_en, output int busy_cyc);
      int  n, k;
      bit  seen;
      ch_active = act;
      ack_dly   = dly;
      got_ch.delete();
      stable_err = 0;
      seen = 1'b0;
      for (int i = 0; i < 70; i++) begin
         @(posedge clk); #1;
         if (busy) begin seen = 1'b1; break; end
      end
      busy_cyc = cyc;
      if (!seen) begin
         total++; bad++;
         $display("FAIL %s_start: busy never rose", name);
         return;
      end
      ch_active = ~act;
      if (drop_en) en = 1'b0;
      n = 1;
      for (int i = 0; i < 80; i++) begin
         if (mix_valid) break;
         @(posedge clk); #1;
         n++;
         if (drop_en && n == 2) en = 1'b1;
      end
      check({name, "_lat"}, 128'(n), 128'(exp_lat));
      check({name, "_enable"}, 128'(sample_enable), 128'(exp_en));
      check({name, "_samples"}, 128'(samples_flat), 128'(exp_s));
      check({name, "_nfetch"}, 128'(got_ch.size()), 128'($countones(act)));
      k = 0;
      for (int c = 0; c < 12; c++) begin
         if (act[c]) begin
            if (k < got_ch.size()) check({name, "_order"}, 128'(got_ch[k]), 128'(c));
            k++;
         end
      end
      check({name, "_req_stable"}, 128'(stable_err), 128'(0));
      @(posedge clk); #1;
      check({name, "_hold"}, {31'd0, mix_valid, samples_flat}, {31'd0, 1'b0, exp_s});
      check({name, "_idle"}, 128'(busy), 128'(0));
   endtask

   initial begin
      int bc, prev_bc, rel;
      vecs[0] = '{"all",    12'hFFF, 0, 12'hFFF, 96'h15141312_11100F0E_0D0C0B0A, 26};
      vecs[1] = '{"sparse", 12'h821, 3, 12'h821, 96'h150000000000_0F000000000A,   17};
      vecs[2] = '{"empty",  12'h000, 0, 12'h000, 96'h0,                           2};
      vecs[3] = '{"pair",   12'h00A, 1, 12'h00A, 96'h0D000B00,                    8};

      #1 nrst = 1'b0;
      en = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outs", {12'd0, samples_flat, sample_enable, mix_valid, busy, overrun,
                           fetch_req, fetch_ch}, 128'd0);
      nrst = 1'b1;
      rel  = cyc;

      prev_bc = rel;
      for (int v = 0; v < 4; v++) begin
         run_seq(vecs[v].name, vecs[v].act, vecs[v].dly, vecs[v].exp_en, vecs[v].exp_s,
                 vecs[v].exp_lat, 1'b0, bc);
         check({vecs[v].name, "_period"}, 128'(bc - prev_bc), 128'(32));
         prev_bc = bc;
      end
      check("no_overrun", 128'(overrun), 128'(0));

      // 12 channels at 4 cycles each overrun the 32-cycle sample period
      run_seq("ovr", 12'hFFF, 2, 12'hFFF, 96'h15141312_11100F0E_0D0C0B0A, 50, 1'b0, bc);
      check("ovr_set", 128'(overrun), 128'(1));
      run_seq("after_ovr", 12'h00A, 1, 12'h00A, 96'h0D000B00, 8, 1'b0, bc);
      check("ovr_sticky", 128'(overrun), 128'(1));
      run_seq("en_drop", 12'h003, 0, 12'h003, 96'h0B0A, 6, 1'b1, bc);
      check("ovr_clr", 128'(overrun), 128'(0));

      // async reset while a fetch is outstanding
      ch_active = 12'h00F;
      ack_dly   = 3;
      for (int i = 0; i < 70; i++) begin
         @(posedge clk); #1;
         if (busy) break;
      end
      @(posedge clk); #1;
      check("rst_inwait_req", 128'(fetch_req), 128'(1));
      nrst = 1'b0;
      #1;
      check("rst_async", {12'd0, samples_flat, sample_enable, mix_valid, busy, overrun,
                          fetch_req, fetch_ch}, 128'd0);
      @(posedge clk); #1;
      nrst = 1'b1;
      rel  = cyc;
      run_seq("post_rst", 12'h00F, 3, 12'h00F, 96'h0D0C0B0A, 22, 1'b0, bc);
      check("post_rst_period", 128'(bc - rel), 128'(32));

`ifdef MIXER_SEQ_TIMEOUT_EN
      never_ch = 3;
      run_seq("tmo", 12'h00F, 0, 12'h007, 96'h0C0B0A, 24, 1'b0, bc);
      check("tmo_req_len", 128'(last_run), 128'(15));
      never_ch = -1;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
